sd_sector_arbiter: RTL and testbench

//  Shares the single user_io SD-image sector channel (sd_lba/sd_rd/sd_wr/sd_ack + 512-byte

---
 rtl/msx_sd_pkg.sv | 14 +
 rtl/rr_pick.sv | 30 +++
 rtl/sd_sector_arbiter.sv | 150 +++++++++++++++
 tb/tb_sd_sector_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/msx_sd_pkg.sv
// Shared types for the MSX SD-image sector path.
package msx_sd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_XFER,
      ST_DONE,
      ST_ERR
   } sd_arb_state_t;

   localparam int unsigned SD_SECTOR_BYTES = 512;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority encoder: first pending requester at or after the pointer, with wrap.
module rr_pick #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IW   = 1
) (
   input  logic [NREQ-1:0] i_pend,
   input  logic [IW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [IW-1:0]   o_idx,
   output logic            o_any
);

   logic [IW-1:0] w_k;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_k     = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         w_k = IW'((32'(i_ptr) + i) % NREQ);
         if (!o_any && i_pend[w_k]) begin
            o_any        = 1'b1;
            o_grant[w_k] = 1'b1;
            o_idx        = w_k;
         end
      end
   end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Shares the single user_io SD sector channel between NREQ requesters, one transaction at a
// time, round-robin, routing buffer strobes and write data only to the granted requester.
module sd_sector_arbiter #(
   parameter int unsigned NREQ    = 2,
   parameter int unsigned TIMEOUT = 2**24
) (
   input  logic              clk_i,
   input  logic              res_n_i,
   input  logic [NREQ-1:0]   req_rd_i,
   input  logic [NREQ-1:0]   req_wr_i,
   input  logic [NREQ*32-1:0] req_lba_i,
   input  logic [NREQ*8-1:0] req_din_i,
   output logic [NREQ-1:0]   req_grant_o,
   output logic [NREQ-1:0]   req_buff_wr_o,
   output logic [NREQ-1:0]   req_din_stb_o,
   output logic [NREQ-1:0]   req_done_o,
   output logic [NREQ-1:0]   req_err_o,
   output logic [31:0]       sd_lba_o,
   output logic              sd_rd_o,
   output logic              sd_wr_o,
   input  logic              sd_ack_i,
   input  logic              sd_buff_wr_i,
   input  logic              sd_din_stb_i,
   output logic [7:0]        sd_buff_din_o,
   output logic              busy_o
);

   import msx_sd_pkg::*;

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

   sd_arb_state_t r_state, w_state_d;
   logic [NREQ-1:0] r_grant;
   logic [IW-1:0]   r_gidx, r_rr;
   logic            r_op_rd, r_op_wr;
   logic [31:0]     r_lba;
   logic [TW-1:0]   r_timer;
   logic            r_ack_q;

   logic [NREQ-1:0] w_pend, w_pick_oh;
   logic [IW-1:0]   w_pick_idx, w_rr_next;
   logic            w_any, w_ack_fall;

   assign w_pend     = req_rd_i | req_wr_i;
   assign w_ack_fall = r_ack_q & ~sd_ack_i;
   assign w_rr_next  = (r_gidx == IW'(NREQ - 1)) ? '0 : r_gidx + 1'b1;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_pick (
      .i_pend  (w_pend),
      .i_ptr   (r_rr),
      .o_grant (w_pick_oh),
      .o_idx   (w_pick_idx),
      .o_any   (w_any)
   );

   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_gidx  <= '0;
         r_rr    <= '0;
         r_op_rd <= 1'b0;
         r_op_wr <= 1'b0;
         r_lba   <= '0;
         r_timer <= '0;
         r_ack_q <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_ack_q <= sd_ack_i;
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_grant <= w_pick_oh;
                  r_gidx  <= w_pick_idx;
                  // Read wins when a requester raises both.
                  r_op_rd <= req_rd_i[w_pick_idx];
                  r_op_wr <= req_wr_i[w_pick_idx] & ~req_rd_i[w_pick_idx];
                  r_lba   <= req_lba_i[w_pick_idx*32 +: 32];
                  r_timer <= '0;
               end
            end
            ST_ISSUE: begin
               if (sd_ack_i) begin
                  r_timer <= '0;
               end else if (r_timer != TMAX) begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            ST_DONE, ST_ERR: begin
               r_grant <= '0;
               r_rr    <= w_rr_next;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_state_d     = r_state;
      sd_rd_o       = 1'b0;
      sd_wr_o       = 1'b0;
      req_buff_wr_o = '0;
      req_din_stb_o = '0;
      req_done_o    = '0;
      req_err_o     = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) w_state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            sd_rd_o = r_op_rd;
            sd_wr_o = r_op_wr;
            if (sd_ack_i) begin
               w_state_d = ST_XFER;
            end else if (r_timer == TMAX) begin
               w_state_d = ST_ERR;
            end
         end
         ST_XFER: begin
            req_buff_wr_o = r_grant & {NREQ{sd_buff_wr_i}};
            req_din_stb_o = r_grant & {NREQ{sd_din_stb_i}};
            if (w_ack_fall) w_state_d = ST_DONE;
         end
         ST_DONE: begin
            req_done_o = r_grant;
            w_state_d  = ST_IDLE;
         end
         ST_ERR: begin
            req_err_o = r_grant;
            w_state_d = ST_IDLE;
         end
         default: w_state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      sd_buff_din_o = '0;
      if (r_grant != '0) sd_buff_din_o = req_din_i[r_gidx*8 +: 8];
   end

   assign req_grant_o = r_grant;
   assign sd_lba_o    = r_lba;
   assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed bench for sd_sector_arbiter with two requesters and a short ack timeout.
module tb_sd_sector_arbiter;

   import msx_sd_pkg::*;

   logic        clk = 1'b0;
   logic        res_n;
   logic [1:0]  req_rd, req_wr;
   logic [63:0] req_lba;
   logic [15:0] req_din;
   logic [1:0]  req_grant_o, req_buff_wr_o, req_din_stb_o, req_done_o, req_err_o;
   logic [31:0] sd_lba_o;
   logic        sd_rd_o, sd_wr_o;
   logic        sd_ack, sd_buff_wr, sd_din_stb;
   logic [7:0]  sd_buff_din_o;
   logic        busy_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sd_sector_arbiter #(
      .NREQ    (2),
      .TIMEOUT (64)
   ) dut (
      .clk_i         (clk),
      .res_n_i       (res_n),
      .req_rd_i      (req_rd),
      .req_wr_i      (req_wr),
      .req_lba_i     (req_lba),
      .req_din_i     (req_din),
      .req_grant_o   (req_grant_o),
      .req_buff_wr_o (req_buff_wr_o),
      .req_din_stb_o (req_din_stb_o),
      .req_done_o    (req_done_o),
      .req_err_o     (req_err_o),
      .sd_lba_o      (sd_lba_o),
      .sd_rd_o       (sd_rd_o),
      .sd_wr_o       (sd_wr_o),
      .sd_ack_i      (sd_ack),
      .sd_buff_wr_i  (sd_buff_wr),
      .sd_din_stb_i  (sd_din_stb),
      .sd_buff_din_o (sd_buff_din_o),
      .busy_o        (busy_o)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for a grant, check it, run a one-cycle ack, check the done pulse.
   task automatic serve(input string tag, input logic [1:0] exp_g, input logic [31:0] exp_lba);
      int n;
      n = 0;
      while (req_grant_o == 2'b00 && n < 8) begin
         tick();
         n++;
      end
      check_eq({tag, "_grant"}, req_grant_o, exp_g);
      check_eq({tag, "_rd"}, sd_rd_o, 1);
      check_eq({tag, "_lba"}, sd_lba_o, exp_lba);
      sd_ack = 1'b1;
      tick();
      sd_ack = 1'b0;
      tick();
      check_eq({tag, "_done"}, req_done_o, exp_g);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no end expected end of test");
      $fatal(1, "bench timed out");
   end

   initial begin
      int c0, c1, n;
      res_n = 1'b0; req_rd = '0; req_wr = '0; req_lba = '0; req_din = '0;
      sd_ack = 1'b0; sd_buff_wr = 1'b0; sd_din_stb = 1'b0;
      #12;
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_grant", req_grant_o, 0);
      check_eq("rst_lba", sd_lba_o, 0);
      check_eq("rst_rdwr", {sd_rd_o, sd_wr_o}, 0);
      res_n = 1'b1;
      tick();

      // Single read on requester 0
      req_rd = 2'b01;
      req_lba[31:0] = 32'h1234;
      tick();
      check_eq("t1_grant", req_grant_o, 2'b01);
      check_eq("t1_rd", sd_rd_o, 1);
      check_eq("t1_wr", sd_wr_o, 0);
      check_eq("t1_lba", sd_lba_o, 32'h1234);
      check_eq("t1_busy", busy_o, 1);
      repeat (3) tick();
      check_eq("t1_rd_hold", sd_rd_o, 1);
      req_rd = 2'b00;
      sd_ack = 1'b1;
      tick();
      check_eq("t1_rd_drop", sd_rd_o, 0);
      c0 = 0; c1 = 0;
      for (int i = 0; i < SD_SECTOR_BYTES; i++) begin
         sd_buff_wr = 1'b1;
         #1;
         if (req_buff_wr_o[0]) c0++;
         if (req_buff_wr_o[1]) c1++;
         tick();
         sd_buff_wr = 1'b0;
      end
      check_eq("t1_strobes0", c0, SD_SECTOR_BYTES);
      check_eq("t1_strobes1", c1, 0);
      check_eq("t1_lba_xfer", sd_lba_o, 32'h1234);
      sd_ack = 1'b0;
      tick();
      check_eq("t1_done", req_done_o, 2'b01);
      tick();
      check_eq("t1_done_pulse", req_done_o, 2'b00);
      check_eq("t1_idle", busy_o, 0);

      // Write on requester 1, data routed from its slice
      req_wr = 2'b10;
      req_lba = {32'd7, 32'hDEAD};
      req_din = 16'hA53C;
      tick();
      check_eq("t3_grant", req_grant_o, 2'b10);
      check_eq("t3_wr", sd_wr_o, 1);
      check_eq("t3_rd", sd_rd_o, 0);
      check_eq("t3_lba", sd_lba_o, 32'd7);
      sd_ack = 1'b1;
      tick();
      req_wr = 2'b00;
      c1 = 0;
      for (int i = 0; i < 4; i++) begin
         sd_din_stb = 1'b1;
         #1;
         if (req_din_stb_o == 2'b10) c1++;
         tick();
         sd_din_stb = 1'b0;
      end
      check_eq("t3_din_stb", c1, 4);
      check_eq("t3_din", sd_buff_din_o, 8'hA5);
      check_eq("t3_no_buffwr", req_buff_wr_o, 0);
      sd_ack = 1'b0;
      tick();
      check_eq("t3_done", req_done_o, 2'b10);
      tick();

      // Both requesters held: round-robin 0, 1, 0
      req_lba = {32'h200, 32'h100};
      req_rd = 2'b11;
      serve("t2a", 2'b01, 32'h100);
      serve("t2b", 2'b10, 32'h200);
      serve("t2c", 2'b01, 32'h100);
      req_rd = 2'b00;
      tick();
      check_eq("t2_idle", busy_o, 0);

      // No ack: error after TIMEOUT cycles in ISSUE
      req_rd = 2'b01;
      tick();
      check_eq("t4_grant", req_grant_o, 2'b01);
      n = 0;
      while (req_err_o == 2'b00 && n < 100) begin
         tick();
         n++;
      end
      check_eq("t4_cycles", n, 64);
      check_eq("t4_err", req_err_o, 2'b01);
      check_eq("t4_rd", sd_rd_o, 0);
      req_rd = 2'b00;
      tick();
      check_eq("t4_err_pulse", req_err_o, 2'b00);
      check_eq("t4_idle", busy_o, 0);

      // Stray strobes and rd&wr on the same requester
      sd_buff_wr = 1'b1; sd_din_stb = 1'b1;
      #1;
      check_eq("t6_stray_idle", {req_buff_wr_o, req_din_stb_o}, 0);
      check_eq("t6_din_idle", sd_buff_din_o, 0);
      sd_buff_wr = 1'b0; sd_din_stb = 1'b0;
      req_rd = 2'b01; req_wr = 2'b01;
      tick();
      check_eq("t6_op", {sd_rd_o, sd_wr_o}, 2'b10);
      sd_buff_wr = 1'b1;
      #1;
      check_eq("t6_stray_issue", req_buff_wr_o, 0);
      sd_buff_wr = 1'b0;
      sd_ack = 1'b1;
      tick();
      sd_ack = 1'b0; req_rd = 2'b00; req_wr = 2'b00;
      tick();
      check_eq("t6_done", req_done_o, 2'b01);
      tick();

      // Reset in the middle of a transfer
      req_rd = 2'b10;
      tick();
      check_eq("t5_grant", req_grant_o, 2'b10);
      sd_ack = 1'b1;
      tick();
      sd_buff_wr = 1'b1;
      #1;
      check_eq("t5_route", req_buff_wr_o, 2'b10);
      res_n = 1'b0;
      #1;
      check_eq("t5_rst_busy", busy_o, 0);
      check_eq("t5_rst_grant", req_grant_o, 0);
      check_eq("t5_rst_strobe", req_buff_wr_o, 0);
      check_eq("t5_rst_lba", sd_lba_o, 0);
      check_eq("t5_rst_rdwr", {sd_rd_o, sd_wr_o}, 0);
      check_eq("t5_rst_din", sd_buff_din_o, 0);
      sd_buff_wr = 1'b0; sd_ack = 1'b0; req_rd = 2'b00;
      @(negedge clk);
      res_n = 1'b1;
      tick();
      req_rd = 2'b11;
      tick();
      check_eq("t5_rr_reset", req_grant_o, 2'b01);
      sd_ack = 1'b1;
      tick();
      sd_ack = 1'b0;
      tick();
      check_eq("t5_done", req_done_o, 2'b01);
      req_rd = 2'b00;
      tick();
      check_eq("t5_idle", busy_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
